// File: rtl/step_history.sv
// step_history: keeps the last NUM_UI symbol edges (time stamp plus signed bit delta)
// and, per evaluation request, emits one saturated time-since-edge and one delta per tap.
// Tap 0 is the newest edge. Results appear one cycle after eval_valid and hold otherwise.
module step_history #(
    parameter int unsigned NUM_UI     = 8,
    parameter int unsigned TIME_WIDTH = 32,
    parameter int unsigned DT_WIDTH   = 16,
    parameter int unsigned DT_MAX     = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_valid,
    input  logic [TIME_WIDTH-1:0]        push_time,
    input  logic                         push_bit,
    input  logic                         eval_valid,
    input  logic [TIME_WIDTH-1:0]        eval_time,
    output logic                         out_valid,
    output logic [NUM_UI*DT_WIDTH-1:0]   out_dt,
    output logic [NUM_UI*2-1:0]          out_delta,
    output logic                         order_err
);

    localparam int unsigned DIFF_W = TIME_WIDTH + 1;
    localparam int unsigned DT_BUS_W = NUM_UI * DT_WIDTH;
    localparam int unsigned DL_BUS_W = NUM_UI * 2;
    localparam logic signed [DIFF_W-1:0] DT_MAX_S = DIFF_W'(DT_MAX);
    localparam logic [DT_WIDTH-1:0]      DT_MAX_W = DT_WIDTH'(DT_MAX);

    // delta encoding: 01 = +1 (rising), 11 = -1 (falling), 00 = no edge
    localparam logic [1:0] DELTA_POS  = 2'b01;
    localparam logic [1:0] DELTA_NEG  = 2'b11;
    localparam logic [1:0] DELTA_ZERO = 2'b00;

    logic [TIME_WIDTH-1:0]   hist_time  [NUM_UI];
    logic [1:0]              hist_delta [NUM_UI];
    logic [NUM_UI-1:0]       hist_vld;
    logic                    prev_bit;
    logic [TIME_WIDTH-1:0]   last_time;

    logic [1:0]              push_delta_c;
    logic                    order_bad_c;
    logic signed [DIFF_W-1:0] diff_c [NUM_UI];
    logic [DT_BUS_W-1:0]     dt_c;
    logic [DL_BUS_W-1:0]     delta_c;

    // Signed bit difference of the incoming symbol versus the previous one
    always_comb begin
        push_delta_c = DELTA_ZERO;
        if (push_bit && !prev_bit) begin
            push_delta_c = DELTA_POS;
        end else if (!push_bit && prev_bit) begin
            push_delta_c = DELTA_NEG;
        end
    end

    // A push earlier than the newest stored edge (including wrap-around) is an ordering error
    always_comb begin
        order_bad_c = push_valid && (|hist_vld) && (push_time < last_time);
    end

    // History shift register plus sticky ordering flag
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_vld  <= '0;
            prev_bit  <= 1'b0;
            last_time <= '0;
            order_err <= 1'b0;
            for (int k = 0; k < NUM_UI; k++) begin
                hist_time[k]  <= '0;
                hist_delta[k] <= DELTA_ZERO;
            end
        end else begin
            if (order_bad_c) begin
                order_err <= 1'b1;
            end
            if (push_valid) begin
                for (int k = NUM_UI - 1; k > 0; k--) begin
                    hist_time[k]  <= hist_time[k-1];
                    hist_delta[k] <= hist_delta[k-1];
                end
                hist_vld      <= {hist_vld[NUM_UI-2:0], 1'b1};
                hist_time[0]  <= push_time;
                hist_delta[0] <= push_delta_c;
                prev_bit      <= push_bit;
                last_time     <= push_time;
            end
        end
    end

    // Per-tap time since edge with saturation and masking of empty/future taps
    always_comb begin
        dt_c    = '0;
        delta_c = '0;
        for (int k = 0; k < NUM_UI; k++) begin
            diff_c[k] = $signed({1'b0, eval_time}) - $signed({1'b0, hist_time[k]});
            if (!hist_vld[k]) begin
                dt_c[k*DT_WIDTH +: DT_WIDTH] = DT_MAX_W;
            end else if (diff_c[k][DIFF_W-1]) begin
                dt_c[k*DT_WIDTH +: DT_WIDTH] = '0;
            end else if (diff_c[k] > DT_MAX_S) begin
                dt_c[k*DT_WIDTH +: DT_WIDTH] = DT_MAX_W;
                delta_c[k*2 +: 2]            = hist_delta[k];
            end else begin
                dt_c[k*DT_WIDTH +: DT_WIDTH] = diff_c[k][DT_WIDTH-1:0];
                delta_c[k*2 +: 2]            = hist_delta[k];
            end
        end
    end

    // Output register: capture on request, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_dt    <= '0;
            out_delta <= '0;
        end else begin
            out_valid <= eval_valid;
            if (eval_valid) begin
                out_dt    <= dt_c;
                out_delta <= delta_c;
            end
        end
    end

endmodule

// File: tb/tb_step_history.sv
// Directed bench for step_history with hand-computed expected tap vectors.
module tb_step_history;

    localparam int unsigned NUM_UI = 8;
    localparam int unsigned TW     = 32;
    localparam int unsigned DW     = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   push_valid;
    logic [TW-1:0]          push_time;
    logic                   push_bit;
    logic                   eval_valid;
    logic [TW-1:0]          eval_time;
    logic                   out_valid;
    logic [NUM_UI*DW-1:0]   out_dt;
    logic [NUM_UI*2-1:0]    out_delta;
    logic                   order_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [NUM_UI*DW-1:0]   e_dt;
    logic [NUM_UI*2-1:0]    e_dl;

    step_history #(.NUM_UI(NUM_UI), .TIME_WIDTH(TW), .DT_WIDTH(DW), .DT_MAX(65535)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_time  (push_time),
        .push_bit   (push_bit),
        .eval_valid (eval_valid),
        .eval_time  (eval_time),
        .out_valid  (out_valid),
        .out_dt     (out_dt),
        .out_delta  (out_delta),
        .order_err  (order_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs set before this are sampled at the edge, outputs read 1 time unit later
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic push(input logic [TW-1:0] t, input logic b);
        push_valid = 1'b1;
        push_time  = t;
        push_bit   = b;
        cycle();
        push_valid = 1'b0;
    endtask

    task automatic eval(input logic [TW-1:0] t);
        eval_valid = 1'b1;
        eval_time  = t;
        cycle();
        eval_valid = 1'b0;
    endtask

    task automatic exp_empty();
        e_dt = {NUM_UI{16'hFFFF}};
        e_dl = '0;
    endtask

    initial begin
        rst = 1'b1; push_valid = 1'b0; push_time = '0; push_bit = 1'b0;
        eval_valid = 1'b0; eval_time = '0;
        cycle();
        cycle();
        rst = 1'b0;

        // reset state
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_order_err", 128'(order_err), 128'(1'b0));
        chk("rst_out_dt",    128'(out_dt),    128'(0));
        chk("rst_out_delta", 128'(out_delta), 128'(0));

        // 1: empty history
        eval(32'd100);
        exp_empty();
        chk("t1_valid", 128'(out_valid), 128'(1'b1));
        chk("t1_dt",    128'(out_dt),    128'(e_dt));
        chk("t1_delta", 128'(out_delta), 128'(e_dl));

        // 2: three edges
        do_reset();
        push(32'd0, 1'b1);
        push(32'd100, 1'b0);
        push(32'd200, 1'b1);
        eval(32'd250);
        exp_empty();
        e_dt[0*DW +: DW] = 16'd50;  e_dl[0 +: 2] = 2'b01;
        e_dt[1*DW +: DW] = 16'd150; e_dl[2 +: 2] = 2'b11;
        e_dt[2*DW +: DW] = 16'd250; e_dl[4 +: 2] = 2'b01;
        chk("t2_valid", 128'(out_valid), 128'(1'b1));
        chk("t2_dt",    128'(out_dt),    128'(e_dt));
        chk("t2_delta", 128'(out_delta), 128'(e_dl));
        cycle();
        chk("t2_idle_valid", 128'(out_valid), 128'(1'b0));
        chk("t2_hold_dt",    128'(out_dt),    128'(e_dt));
        chk("t2_hold_delta", 128'(out_delta), 128'(e_dl));

        // 3: push and eval in the same cycle
        do_reset();
        push_valid = 1'b1; push_time = 32'd1000; push_bit = 1'b1;
        eval_valid = 1'b1; eval_time = 32'd1000;
        cycle();
        push_valid = 1'b0;
        exp_empty();
        chk("t3_same_valid", 128'(out_valid), 128'(1'b1));
        chk("t3_same_dt",    128'(out_dt),    128'(e_dt));
        chk("t3_same_delta", 128'(out_delta), 128'(e_dl));
        eval_time = 32'd1000;
        cycle();
        eval_valid = 1'b0;
        e_dt[0*DW +: DW] = 16'd0; e_dl[0 +: 2] = 2'b01;
        chk("t3_next_dt",    128'(out_dt),    128'(e_dt));
        chk("t3_next_delta", 128'(out_delta), 128'(e_dl));

        // 4: saturation and future-edge masking
        do_reset();
        push(32'd0, 1'b1);
        eval(32'd65535);
        exp_empty();
        e_dt[0*DW +: DW] = 16'd65535; e_dl[0 +: 2] = 2'b01;
        chk("t4_edge_dt",    128'(out_dt),    128'(e_dt));
        chk("t4_edge_delta", 128'(out_delta), 128'(e_dl));
        eval(32'd70000);
        chk("t4_sat_dt",    128'(out_dt),    128'(e_dt));
        chk("t4_sat_delta", 128'(out_delta), 128'(e_dl));
        push(32'd600, 1'b0);
        eval(32'd500);
        exp_empty();
        e_dt[0*DW +: DW] = 16'd0;   e_dl[0 +: 2] = 2'b00;
        e_dt[1*DW +: DW] = 16'd500; e_dl[2 +: 2] = 2'b01;
        chk("t4_future_dt",    128'(out_dt),    128'(e_dt));
        chk("t4_future_delta", 128'(out_delta), 128'(e_dl));
        chk("t4_order_ok",     128'(order_err), 128'(1'b0));

        // 5: ten alternating pushes, oldest two aged out
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push(TW'(i * 100), ((i % 2) == 0));
        end
        eval(32'd950);
        for (int k = 0; k < 8; k++) begin
            e_dt[k*DW +: DW] = DW'(50 + 100 * k);
            e_dl[k*2 +: 2]   = ((k % 2) == 0) ? 2'b11 : 2'b01;
        end
        chk("t5_dt",    128'(out_dt),    128'(e_dt));
        chk("t5_delta", 128'(out_delta), 128'(e_dl));
        chk("t5_order", 128'(order_err), 128'(1'b0));

        // 6: ordering error, sticky, cleared by reset mid-eval
        do_reset();
        push(32'd500, 1'b1);
        chk("t6_first_ok", 128'(order_err), 128'(1'b0));
        push(32'd400, 1'b0);
        chk("t6_err_set", 128'(order_err), 128'(1'b1));
        push(32'd900, 1'b1);
        cycle();
        chk("t6_err_sticky", 128'(order_err), 128'(1'b1));
        rst = 1'b1; eval_valid = 1'b1; eval_time = 32'd1000;
        cycle();
        rst = 1'b0; eval_valid = 1'b0;
        chk("t6_rst_valid", 128'(out_valid), 128'(1'b0));
        chk("t6_rst_err",   128'(order_err), 128'(1'b0));
        chk("t6_rst_dt",    128'(out_dt),    128'(0));
        eval(32'd1000);
        exp_empty();
        chk("t6_clear_dt",    128'(out_dt),    128'(e_dt));
        chk("t6_clear_delta", 128'(out_delta), 128'(e_dl));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
